// File: rtl/md_unit_pkg.sv
// Shared MD-class op codes, FSM state type and small decode helpers.
package md_unit_pkg;

    // MD op codes; unlisted codes decode as mdNone
    localparam logic [3:0] mdNone  = 4'd0;
    localparam logic [3:0] mdMult  = 4'd1;
    localparam logic [3:0] mdMultu = 4'd2;
    localparam logic [3:0] mdDiv   = 4'd3;
    localparam logic [3:0] mdDivu  = 4'd4;
    localparam logic [3:0] mdMthi  = 4'd5;
    localparam logic [3:0] mdMtlo  = 4'd6;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } mdState_e;

    // True for the four ops that occupy the unit for a multi-cycle latency
    function automatic logic isLaunchOp(input logic [3:0] op);
        return (op == mdMult) || (op == mdMultu) || (op == mdDiv) || (op == mdDivu);
    endfunction

    function automatic logic isDivOp(input logic [3:0] op);
        return (op == mdDiv) || (op == mdDivu);
    endfunction

endpackage

// File: rtl/md_unit.sv
// Multiply/divide controller: owns HI/LO, runs one mult/div at a time with fixed latency.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    mdState_e    stateQ, stateD;
    logic [3:0]  cntQ, cntD;
    logic [63:0] pendQ, pendD;
    logic        pendWrQ, pendWrD;
    logic [31:0] hiQ, hiD;
    logic [31:0] loQ, loD;

    logic        launch;
    logic        bZero;
    logic        divOvf;
    logic [63:0] prodS, prodU;
    logic signed [63:0] sA64, sB64;
    logic signed [31:0] sA, sBSafe, sQuot, sRem;
    logic [31:0] uBSafe, uQuot, uRem;

    // Launch is only honoured from IDLE; anything arriving in RUN is dropped
    always_comb begin
        launch = (stateQ == StIdle) && start && isLaunchOp(op);
    end

    // Arithmetic on the operands presented at launch; divisor forced safe so the
    // zero-divisor and INT_MIN/-1 cases never reach the dividers
    always_comb begin
        bZero  = (B == 32'd0);
        divOvf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);

        sA64  = {{32{A[31]}}, A};
        sB64  = {{32{B[31]}}, B};
        prodS = 64'(sA64 * sB64);
        prodU = {32'd0, A} * {32'd0, B};

        sA     = $signed(A);
        sBSafe = (bZero || divOvf) ? 32'sd1 : $signed(B);
        if (divOvf) begin
            sQuot = 32'sh8000_0000;
            sRem  = 32'sd0;
        end else begin
            sQuot = sA / sBSafe;
            sRem  = sA % sBSafe;
        end

        uBSafe = bZero ? 32'd1 : B;
        uQuot  = A / uBSafe;
        uRem   = A % uBSafe;
    end

    // Pending result captured on the launch edge; a zero divisor suppresses the commit
    always_comb begin
        pendD   = pendQ;
        pendWrD = pendWrQ;
        if (launch) begin
            case (op)
                mdMult: begin
                    pendD   = prodS;
                    pendWrD = 1'b1;
                end
                mdMultu: begin
                    pendD   = prodU;
                    pendWrD = 1'b1;
                end
                mdDiv: begin
                    pendD   = {sRem, sQuot};
                    pendWrD = !bZero;
                end
                mdDivu: begin
                    pendD   = {uRem, uQuot};
                    pendWrD = !bZero;
                end
                default: begin
                    pendD   = pendQ;
                    pendWrD = pendWrQ;
                end
            endcase
        end
    end

    // FSM next state, latency counter, HI/LO writes from mthi/mtlo and commit
    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        hiD    = hiQ;
        loD    = loQ;
        unique case (stateQ)
            StIdle: begin
                if (launch) begin
                    stateD = StRun;
                    cntD   = isDivOp(op) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                end else if (op == mdMthi) begin
                    // Acts on op alone; start is not required for moves
                    hiD = A;
                end else if (op == mdMtlo) begin
                    loD = A;
                end
            end
            StRun: begin
                cntD = cntQ - 4'd1;
                if (cntQ == 4'd1) begin
                    stateD = StIdle;
                    if (pendWrQ) begin
                        hiD = pendQ[63:32];
                        loD = pendQ[31:0];
                    end
                end
            end
            default: begin
                stateD = StIdle;
            end
        endcase
    end

    // State registers with synchronous reset that also discards any in-flight result
    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ  <= StIdle;
            cntQ    <= 4'd0;
            pendQ   <= 64'd0;
            pendWrQ <= 1'b0;
            hiQ     <= 32'd0;
            loQ     <= 32'd0;
        end else begin
            stateQ  <= stateD;
            cntQ    <= cntD;
            pendQ   <= pendD;
            pendWrQ <= pendWrD;
            hiQ     <= hiD;
            loQ     <= loD;
        end
    end

    // Outputs come straight from registers
    always_comb begin
        busy = (stateQ == StRun);
        HI   = hiQ;
        LO   = loQ;
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: cycle-level reference model plus directed literal checks.
module tb_md_unit;
    import md_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int tests = 0;
    int fails = 0;
    logic chkEn = 1'b0;

    md_unit #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .op   (op),
        .A    (A),
        .B    (B),
        .busy (busy),
        .HI   (HI),
        .LO   (LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference arithmetic: {commit, hi, lo}
    function automatic logic [64:0] modelResult(input logic [3:0] o, input logic [31:0] a,
                                                input logic [31:0] b);
        longint na, nb, ma, mb, q, r;
        logic [63:0] p;
        case (o)
            4'd1: begin
                na = longint'($signed(a));
                nb = longint'($signed(b));
                p  = 64'(na * nb);
                return {1'b1, p};
            end
            4'd2: begin
                p = 64'(a) * 64'(b);
                return {1'b1, p};
            end
            4'd3: begin
                if (b == 32'd0) return {1'b0, 64'd0};
                na = longint'($signed(a));
                nb = longint'($signed(b));
                ma = (na < 0) ? -na : na;
                mb = (nb < 0) ? -nb : nb;
                q  = ma / mb;
                r  = ma % mb;
                if ((na < 0) != (nb < 0)) q = -q;
                if (na < 0) r = -r;
                return {1'b1, r[31:0], q[31:0]};
            end
            4'd4: begin
                if (b == 32'd0) return {1'b0, 64'd0};
                return {1'b1, a % b, a / b};
            end
            default: return 65'd0;
        endcase
    endfunction

    // Model: busy while the current cycle precedes the first idle cycle doneCyc
    longint      cyc = 0;
    longint      doneCyc = 0;
    logic [31:0] mHi = 32'd0, mLo = 32'd0, pHi = 32'd0, pLo = 32'd0;
    logic        pOk = 1'b0;

    always @(posedge clk) begin
        logic [64:0] res;
        cyc <= cyc + 1;
        if (reset) begin
            mHi     <= 32'd0;
            mLo     <= 32'd0;
            doneCyc <= 0;
            pOk     <= 1'b0;
        end else if (cyc < doneCyc) begin
            if ((cyc + 1 == doneCyc) && pOk) begin
                mHi <= pHi;
                mLo <= pLo;
            end
        end else if (start && op >= 4'd1 && op <= 4'd4) begin
            res     = modelResult(op, A, B);
            pOk     <= res[64];
            pHi     <= res[63:32];
            pLo     <= res[31:0];
            doneCyc <= cyc + ((op >= 4'd3) ? 10 : 5) + 1;
        end else if (op == 4'd5) begin
            mHi <= A;
        end else if (op == 4'd6) begin
            mLo <= A;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chkEn) begin
            check("busy", 32'(busy), 32'(cyc < doneCyc));
            check("HI", HI, mHi);
            check("LO", LO, mLo);
        end
    end

    // Present inputs for one edge, then return to idle inputs
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic s);
        start = s;
        op    = o;
        A     = a;
        B     = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = mdNone;
        A     = 32'd0;
        B     = 32'd0;
    endtask

    // Count busy cycles until idle (bounded); ends at the negedge of the first idle cycle
    task automatic busyLen(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        start = 1'b0;
        op    = mdNone;
        A     = 32'd0;
        B     = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chkEn = 1'b1;
        @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset HI", HI, 32'd0);
        check("reset LO", LO, 32'd0);

        // mult -3 * 5
        issue(mdMult, 32'hFFFF_FFFD, 32'd5, 1'b1);
        busyLen(n);
        check("mult busy len", n, 32'd5);
        check("mult HI", HI, 32'hFFFF_FFFF);
        check("mult LO", LO, 32'hFFFF_FFF1);

        // multu then div launched in the first idle cycle
        issue(mdMultu, 32'hFFFF_FFFF, 32'd2, 1'b1);
        busyLen(n);
        check("multu busy len", n, 32'd5);
        check("multu HI", HI, 32'h0000_0001);
        check("multu LO", LO, 32'hFFFF_FFFE);
        issue(mdDiv, 32'hFFFF_FFF9, 32'd2, 1'b1);
        busyLen(n);
        check("div busy len", n, 32'd10);
        check("div LO", LO, 32'hFFFF_FFFD);
        check("div HI", HI, 32'hFFFF_FFFF);

        // mthi with start, mtlo without start, then divu by zero
        issue(mdMthi, 32'h11, 32'd0, 1'b1);
        issue(mdMtlo, 32'h22, 32'd0, 1'b0);
        @(negedge clk);
        check("mthi HI", HI, 32'h11);
        check("mtlo LO", LO, 32'h22);
        issue(mdDivu, 32'd7, 32'd0, 1'b1);
        busyLen(n);
        check("divu0 busy len", n, 32'd10);
        check("divu0 HI", HI, 32'h11);
        check("divu0 LO", LO, 32'h22);

        // mthi and a relaunch during busy are both ignored
        issue(mdMult, 32'h1234_5678, 32'h100, 1'b1);
        issue(mdMthi, 32'hDEAD, 32'd0, 1'b1);
        issue(mdDivu, 32'd100, 32'd3, 1'b1);
        busyLen(n);
        check("ignored busy rest", n, 32'd3);
        check("ignored HI", HI, 32'h0000_0012);
        check("ignored LO", LO, 32'h3456_7800);
        @(negedge clk);
        check("no relaunch", 32'(busy), 32'd0);

        // reset in the 4th busy cycle of div 100/7
        issue(mdDiv, 32'd100, 32'd7, 1'b1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst busy", 32'(busy), 32'd0);
        check("rst HI", HI, 32'd0);
        check("rst LO", LO, 32'd0);
        repeat (12) @(negedge clk);
        check("rst no commit HI", HI, 32'd0);
        check("rst no commit LO", LO, 32'd0);

        // INT_MIN / -1
        issue(mdDiv, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        busyLen(n);
        check("ovf LO", LO, 32'h8000_0000);
        check("ovf HI", HI, 32'd0);

        // plain divu
        issue(mdDivu, 32'hFFFF_FFFF, 32'd16, 1'b1);
        busyLen(n);
        check("divu LO", LO, 32'h0FFF_FFFF);
        check("divu HI", HI, 32'h0000_000F);

        // undefined op code with start does nothing
        issue(4'd9, 32'h55, 32'h3, 1'b1);
        @(negedge clk);
        check("bad op busy", 32'(busy), 32'd0);
        check("bad op HI", HI, 32'h0000_000F);
        check("bad op LO", LO, 32'h0FFF_FFFF);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
